// File: rtl/seg7_pkg.sv
// Shared types, glyph table and register-map helpers for the seven-segment scan controller.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  // Active-high glyphs, bit6..0 = g..a; bit7 (dp) is left clear here.
  localparam seg_t GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // DP and EN registers sit directly after the nibble registers.
  localparam int OFS_DP = 0;
  localparam int OFS_EN = 1;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + decimal point to active-high segment vector.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output seg_t       seg_o
);

  seg_t glyph;

  assign glyph = GLYPH[nibble_i];
  assign seg_o = {dp_i, glyph[6:0]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped multi-digit seven-segment scan controller with blank gap between digits.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int         NUM_DIGITS   = 4,
  parameter int         SCAN_DIV     = 50000,
  parameter int         BLANK_CYCLES = 2,
  parameter logic [7:0] BASE_ADDR    = 8'hD0,
  parameter int         ACTIVE_LOW   = 1
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [7:0]            BUS_ADDR,
  input  logic [7:0]            BUS_DATA,
  input  logic                  BUS_WE,
  output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
  output logic [7:0]            HEX_OUT
);

  localparam int   NREG  = ceil_div(NUM_DIGITS, 2);
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);
  localparam scan_state_t RST_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [3:0]            nib_q [NUM_DIGITS];
  logic [3:0]            nib_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q, dp_d, en_q, en_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_t           state_q, state_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d, sel_act;
  seg_t                  hex_q, hex_d, hex_act;
  logic [7:0]            ofs;
  logic [3:0]            nib_cur;
  logic                  dp_cur;
  logic                  lzb_blank;
  seg_t                  dec_seg;

  // Register writes; the offset is taken modulo 256 so addresses below BASE never alias.
  always_comb begin
    ofs   = BUS_ADDR - BASE_ADDR;
    nib_d = nib_q;
    dp_d  = dp_q;
    en_d  = en_q;
    if (BUS_WE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (ofs == 8'(k / 2)) nib_d[k] = (k % 2 == 1) ? BUS_DATA[7:4] : BUS_DATA[3:0];
      end
      if (ofs == 8'(NREG + OFS_DP)) dp_d = BUS_DATA[NUM_DIGITS-1:0];
      if (ofs == 8'(NREG + OFS_EN)) en_d = BUS_DATA[NUM_DIGITS-1:0];
    end
  end

  // Slot counter and digit index; the state follows the counter value it will hold.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    state_d = (cnt_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
  end

  assign nib_cur = nib_q[idx_q];
  assign dp_cur  = dp_q[idx_q];

  seg7_hex_decoder u_dec (
    .nibble_i (nib_cur),
    .dp_i     (dp_cur),
    .seg_o    (dec_seg)
  );

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] lz_from;

  // lz_from[k] is set when digits k..NUM_DIGITS-1 all hold zero.
  always_comb begin
    logic acc;
    acc = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc        = acc && (nib_q[k] == 4'h0);
      lz_from[k] = acc;
    end
  end

  assign lzb_blank = (idx_q != '0) && lz_from[idx_q] && !dp_cur;
`else
  assign lzb_blank = 1'b0;
`endif

  // Disabled digits still drive segments; only their select stays off.
  always_comb begin
    sel_act = '0;
    hex_act = '0;
    if (state_q == ST_SHOW && !lzb_blank) begin
      hex_act = dec_seg;
      if (en_q[idx_q]) sel_act[idx_q] = 1'b1;
    end
    sel_d = sel_act ^ {NUM_DIGITS{POL}};
    hex_d = hex_act ^ {8{POL}};
  end

  // NOTE: every flop, including the digit nibble array, is cleared by reset so
  // a reset mid-scan restarts cleanly; state updates use <= only.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) nib_q[k] <= '0;
      dp_q    <= '0;
      en_q    <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= RST_STATE;
      sel_q   <= {NUM_DIGITS{POL}};
      hex_q   <= {8{POL}};
    end else begin
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      hex_q   <= hex_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;
  assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed steps then random bus traffic against a slot-arithmetic model.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int PERIOD = ND * DIV;

  localparam logic [6:0] GLYPH_AH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk_sys = 1'b0;
  logic          rst;
  logic [7:0]    BUS_ADDR;
  logic [7:0]    BUS_DATA;
  logic          BUS_WE;
  logic [ND-1:0] SEG_SELECT_OUT;
  logic [7:0]    HEX_OUT;

  int checks   = 0;
  int failures = 0;

  // Reference state: register contents and cycles elapsed since reset release.
  logic [3:0]    m_nib [ND];
  logic [ND-1:0] m_dp;
  logic [ND-1:0] m_en;
  int            cyc;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (DIV),
    .BLANK_CYCLES (BLANK),
    .BASE_ADDR    (8'hD0),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_DATA       (BUS_DATA),
    .BUS_WE         (BUS_WE),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .HEX_OUT        (HEX_OUT)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void model_out(input int c, output logic [ND-1:0] s, output logic [7:0] h);
    int  pos, d, ph;
    logic [ND-1:0] sel;
    logic [7:0] hx;
    logic blank_lz;
    pos = c % PERIOD;
    d   = pos / DIV;
    ph  = pos % DIV;
    sel = '0;
    hx  = '0;
    blank_lz = 1'b0;
`ifdef SEG7_LZB_EN
    if (d > 0 && !m_dp[d]) begin
      blank_lz = 1'b1;
      for (int j = d; j < ND; j++) if (m_nib[j] != 4'h0) blank_lz = 1'b0;
    end
`endif
    if (ph >= BLANK && !blank_lz) begin
      hx = {m_dp[d], GLYPH_AH[m_nib[d]]};
      if (m_en[d]) sel[d] = 1'b1;
    end
    s = ~sel;
    h = ~hx;
  endfunction

  task automatic tick(input string tag);
    logic [ND-1:0] es;
    logic [7:0]    eh;
    int            o;
    if (rst) begin
      es = '1;
      eh = 8'hFF;
      for (int k = 0; k < ND; k++) m_nib[k] = 4'h0;
      m_dp = '0;
      m_en = '1;
      cyc  = 0;
    end else begin
      model_out(cyc, es, eh);
      if (BUS_WE) begin
        o = int'(BUS_ADDR) - 'hD0;
        if (o == 0 || o == 1) begin
          m_nib[2*o]   = BUS_DATA[3:0];
          m_nib[2*o+1] = BUS_DATA[7:4];
        end else if (o == 2) m_dp = BUS_DATA[ND-1:0];
        else if (o == 3) m_en = BUS_DATA[ND-1:0];
      end
      cyc++;
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    assert (SEG_SELECT_OUT === es) else begin
      failures++;
      $error("FAIL %s SEG got=%b exp=%b cyc=%0d", tag, SEG_SELECT_OUT, es, cyc);
    end
    checks++;
    assert (HEX_OUT === eh) else begin
      failures++;
      $error("FAIL %s HEX got=%h exp=%h cyc=%0d", tag, HEX_OUT, eh, cyc);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE   = 1'b1;
    tick(tag);
    BUS_WE   = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  initial begin
    rst      = 1'b1;
    BUS_ADDR = 8'h00;
    BUS_DATA = 8'h00;
    BUS_WE   = 1'b0;
    for (int k = 0; k < ND; k++) m_nib[k] = 4'h0;
    m_dp = '0;
    m_en = '1;
    cyc  = 0;
    @(negedge clk_sys);

    run(3, "reset");
    rst = 1'b0;
    run(40, "idle_zero");

    bus_write(8'hD0, 8'h21, "wr_d0");
    bus_write(8'hD1, 8'h43, "wr_d1");
    run(40, "digits_1234");

    bus_write(8'hD2, 8'h05, "wr_dp");
    run(40, "dp_0_2");

    bus_write(8'hD3, 8'h0A, "wr_en");
    run(40, "en_1_3");

    while (cyc % PERIOD != 2 * DIV + 3) tick("seek_d2");
    rst = 1'b1;
    tick("rst_pulse");
    rst = 1'b0;
    run(40, "after_rst");

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!rst && $urandom_range(0, 3) == 0)
        bus_write(8'($urandom_range(8'hCE, 8'hD5)), 8'($urandom), "rand_wr");
      else
        tick("rand_run");
    end
    rst = 1'b0;
    run(PERIOD, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
